// File: rtl/apple_spawner.sv
// apple_spawner: picks a pseudo-random free grid cell for the next apple.
// A free-running 16-bit LFSR supplies candidates. Each candidate is checked
// against the grid bounds and the snake head. It is then checked against
// every body segment, which are read one per cycle from an external
// synchronous RAM.
// Optional feature: define APPLE_SPAWNER_EAT_COUNT_EN to enable the
// eat_count counter. Without it, eat_count is tied to zero.
module apple_spawner #(
  parameter int          XW        = 5,
  parameter int          YW        = 5,
  parameter int          GRID_W    = 20,
  parameter int          GRID_H    = 20,
  parameter int          MAX_LEN   = 64,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         LW        = $clog2(MAX_LEN + 1),
  localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          spawn_req,
  input  logic [XW-1:0] head_x,
  input  logic [YW-1:0] head_y,
  input  logic          head_vld,
  input  logic [LW-1:0] body_len,
  output logic [AW-1:0] body_addr,
  output logic          body_rd,
  input  logic [XW-1:0] body_x,
  input  logic [YW-1:0] body_y,
  output logic [XW-1:0] apple_x,
  output logic [YW-1:0] apple_y,
  output logic          apple_vld,
  output logic          eaten,
  output logic          busy,
  output logic [15:0]   eat_count
);

  typedef enum logic [1:0] {IDLE, GEN, SCAN, PLACED} state_t;

  localparam logic [XW:0]   GW   = GRID_W[XW:0];
  localparam logic [YW:0]   GH   = GRID_H[YW:0];
  localparam logic [LW-1:0] MAXL = MAX_LEN[LW-1:0];

  state_t        state, nxt;
  logic [15:0]   lfsr;
  logic          lfsr_fb;
  logic [XW-1:0] gen_x, cand_x, place_x;
  logic [YW-1:0] gen_y, cand_y, place_y;
  logic [LW-1:0] len_lim, scan_len, rd_idx;
  logic          cmp_vld, gen_ok, seg_hit, last_cmp, eat_hit;
  logic          accept, place;

  assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign gen_x    = lfsr[XW-1:0];
  assign gen_y    = lfsr[XW+YW-1:XW];
  assign gen_ok   = ({1'b0, gen_x} < GW) && ({1'b0, gen_y} < GH) &&
                    !(head_vld && gen_x == head_x && gen_y == head_y);
  assign len_lim  = (body_len > MAXL) ? MAXL : body_len;
  // Read data lags body_rd by one cycle, so compares trail reads by one.
  assign seg_hit  = cmp_vld && body_x == cand_x && body_y == cand_y;
  assign last_cmp = cmp_vld && (rd_idx == scan_len);
  assign eat_hit  = (state == PLACED) && apple_vld && head_vld &&
                    head_x == apple_x && head_y == apple_y;

  assign busy      = (state == GEN) || (state == SCAN);
  assign body_rd   = (state == SCAN) && (rd_idx < scan_len);
  assign body_addr = body_rd ? rd_idx[AW-1:0] : '0;

  // Free-running LFSR; a nonzero seed keeps it off the all-zero lockup state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else        lfsr <= {lfsr[14:0], lfsr_fb};
  end

  // Next-state and placement decisions.
  always_comb begin
    nxt     = state;
    accept  = 1'b0;
    place   = 1'b0;
    place_x = cand_x;
    place_y = cand_y;
    case (state)
      IDLE, PLACED: if (spawn_req || eaten) nxt = GEN;
      GEN: begin
        if (gen_ok) begin
          accept = 1'b1;
          if (len_lim == '0) begin
            place   = 1'b1;
            place_x = gen_x;
            place_y = gen_y;
            nxt     = PLACED;
          end else begin
            nxt = SCAN;
          end
        end
      end
      SCAN: begin
        if (seg_hit) begin
          nxt = GEN;
        end else if (last_cmp) begin
          place = 1'b1;
          nxt   = PLACED;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // State register, candidate latch, scan pointer and apple outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cand_x    <= '0;
      cand_y    <= '0;
      scan_len  <= '0;
      rd_idx    <= '0;
      cmp_vld   <= 1'b0;
      apple_x   <= '0;
      apple_y   <= '0;
      apple_vld <= 1'b0;
      eaten     <= 1'b0;
    end else begin
      state   <= nxt;
      cmp_vld <= body_rd;
      if (accept) begin
        cand_x   <= gen_x;
        cand_y   <= gen_y;
        scan_len <= len_lim;
        rd_idx   <= '0;
      end else if (body_rd) begin
        rd_idx <= rd_idx + LW'(1);
      end
      if (place) begin
        apple_x   <= place_x;
        apple_y   <= place_y;
        apple_vld <= 1'b1;
      end else if (eat_hit) begin
        apple_vld <= 1'b0;
      end
      eaten <= eat_hit;
    end
  end

`ifdef APPLE_SPAWNER_EAT_COUNT_EN
  // Eat counter; updates on the same edge that raises eaten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       eat_count <= '0;
    else if (eat_hit) eat_count <= eat_count + 16'd1;
  end
`else
  assign eat_count = '0;
`endif

endmodule

// File: tb/tb_apple_spawner.sv
// Directed bench for apple_spawner. There are three instances:
//   u_main  - default parameters and seed
//   u_frc   - seed chosen so the lfsr reads 16'h0022 (candidate (2,1)) in
//             the GEN cycle three edges after reset release
//   u_small - 3x3 grid with 2-bit coordinates
module tb_apple_spawner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // One backward LFSR step: old = {new[0]^new[14]^new[13]^new[11], new[15:1]}
  function automatic logic [15:0] lfsr_back(input logic [15:0] v, input int n);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[0] ^ r[14] ^ r[13] ^ r[11], r[15:1]};
    return r;
  endfunction

  localparam logic [15:0] F_SEED = lfsr_back(16'h0022, 3);

`ifdef APPLE_SPAWNER_EAT_COUNT_EN
  localparam logic [15:0] EXP_EAT1 = 16'd1;
`else
  localparam logic [15:0] EXP_EAT1 = 16'd0;
`endif

  // ---------------- main instance
  logic       m_rst_n, m_spawn_req, m_head_vld, m_body_rd;
  logic [4:0] m_head_x, m_head_y, m_body_x, m_body_y, m_apple_x, m_apple_y;
  logic [6:0] m_body_len;
  logic [5:0] m_body_addr;
  logic       m_apple_vld, m_eaten, m_busy;
  logic [15:0] m_eat_count;
  logic [4:0] m_seg_x [64];
  logic [4:0] m_seg_y [64];

  apple_spawner u_main (
    .clk(clk), .rst_n(m_rst_n), .spawn_req(m_spawn_req),
    .head_x(m_head_x), .head_y(m_head_y), .head_vld(m_head_vld),
    .body_len(m_body_len), .body_addr(m_body_addr), .body_rd(m_body_rd),
    .body_x(m_body_x), .body_y(m_body_y),
    .apple_x(m_apple_x), .apple_y(m_apple_y), .apple_vld(m_apple_vld),
    .eaten(m_eaten), .busy(m_busy), .eat_count(m_eat_count)
  );

  always @(posedge clk) if (m_body_rd) begin
    m_body_x <= m_seg_x[m_body_addr];
    m_body_y <= m_seg_y[m_body_addr];
  end

  // ---------------- forced-seed instance
  logic       f_rst_n, f_spawn_req, f_head_vld, f_body_rd;
  logic [4:0] f_head_x, f_head_y, f_body_x, f_body_y, f_apple_x, f_apple_y;
  logic [6:0] f_body_len;
  logic [5:0] f_body_addr;
  logic       f_apple_vld, f_eaten, f_busy;
  logic [15:0] f_eat_count;
  logic [4:0] f_seg_x [64];
  logic [4:0] f_seg_y [64];

  apple_spawner #(.LFSR_SEED(F_SEED)) u_frc (
    .clk(clk), .rst_n(f_rst_n), .spawn_req(f_spawn_req),
    .head_x(f_head_x), .head_y(f_head_y), .head_vld(f_head_vld),
    .body_len(f_body_len), .body_addr(f_body_addr), .body_rd(f_body_rd),
    .body_x(f_body_x), .body_y(f_body_y),
    .apple_x(f_apple_x), .apple_y(f_apple_y), .apple_vld(f_apple_vld),
    .eaten(f_eaten), .busy(f_busy), .eat_count(f_eat_count)
  );

  always @(posedge clk) if (f_body_rd) begin
    f_body_x <= f_seg_x[f_body_addr];
    f_body_y <= f_seg_y[f_body_addr];
  end

  // ---------------- small-grid instance
  logic       s_rst_n, s_spawn_req, s_body_rd, s_apple_vld, s_eaten, s_busy;
  logic [1:0] s_apple_x, s_apple_y;
  logic [1:0] s_zero2 = 2'd0;
  logic [6:0] s_body_len = 7'd0;
  logic [5:0] s_body_addr;
  logic [15:0] s_eat_count;
  logic       s_head_vld = 1'b0;

  apple_spawner #(.XW(2), .YW(2), .GRID_W(3), .GRID_H(3)) u_small (
    .clk(clk), .rst_n(s_rst_n), .spawn_req(s_spawn_req),
    .head_x(s_zero2), .head_y(s_zero2), .head_vld(s_head_vld),
    .body_len(s_body_len), .body_addr(s_body_addr), .body_rd(s_body_rd),
    .body_x(s_zero2), .body_y(s_zero2),
    .apple_x(s_apple_x), .apple_y(s_apple_y), .apple_vld(s_apple_vld),
    .eaten(s_eaten), .busy(s_busy), .eat_count(s_eat_count)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    m_rst_n = 0; f_rst_n = 0; s_rst_n = 0;
    m_spawn_req = 0; f_spawn_req = 0; s_spawn_req = 0;
    m_head_vld = 0; f_head_vld = 0; m_head_x = 0; m_head_y = 0; f_head_x = 0; f_head_y = 0;
    m_body_len = 0; f_body_len = 0;
    for (int i = 0; i < 64; i++) begin
      m_seg_x[i] = 5'd31; m_seg_y[i] = 5'd31; f_seg_x[i] = 5'd31; f_seg_y[i] = 5'd31;
    end
    tick(); tick();
    total++; if ({m_apple_vld, m_eaten, m_busy, m_body_rd} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags: got %b want 0000", {m_apple_vld, m_eaten, m_busy, m_body_rd});
    end
    total++; if ({m_apple_x, m_apple_y, m_body_addr} !== 16'h0) begin
      bad++; $display("FAIL reset_coords: got %h want 0", {m_apple_x, m_apple_y, m_body_addr});
    end
    total++; if (m_eat_count !== 16'd0) begin
      bad++; $display("FAIL reset_eat_count: got %0d want 0", m_eat_count);
    end
    total++; if (u_main.lfsr !== 16'hACE1) begin
      bad++; $display("FAIL reset_lfsr: got %h want ace1", u_main.lfsr);
    end
  endtask

  // Spawn sampled on the first edge after release: lfsr 16'hACE1 -> 16'h59C3
  // gives candidate (3,14), placed one edge later.
  task automatic test_spawn_empty();
    m_rst_n = 1; m_spawn_req = 1;
    tick(); m_spawn_req = 0;
    total++; if ({m_busy, m_apple_vld} !== 2'b10) begin
      bad++; $display("FAIL spawn_gen: got busy,vld=%b want 10", {m_busy, m_apple_vld});
    end
    tick();
    total++; if ({m_busy, m_apple_vld} !== 2'b01) begin
      bad++; $display("FAIL spawn_placed: got busy,vld=%b want 01", {m_busy, m_apple_vld});
    end
    total++; if ({m_apple_x, m_apple_y} !== {5'd3, 5'd14}) begin
      bad++; $display("FAIL spawn_apple: got (%0d,%0d) want (3,14)", m_apple_x, m_apple_y);
    end
  endtask

  task automatic test_eat();
    m_head_x = 5'd3; m_head_y = 5'd14; m_head_vld = 1;
    tick();
    total++; if ({m_eaten, m_apple_vld, m_busy} !== 3'b100) begin
      bad++; $display("FAIL eat_pulse: got eaten,vld,busy=%b want 100", {m_eaten, m_apple_vld, m_busy});
    end
    total++; if (m_eat_count !== EXP_EAT1) begin
      bad++; $display("FAIL eat_count: got %0d want %0d", m_eat_count, EXP_EAT1);
    end
    tick();
    total++; if ({m_eaten, m_busy} !== 2'b01) begin
      bad++; $display("FAIL eat_regen: got eaten,busy=%b want 01", {m_eaten, m_busy});
    end
    total++; if ({m_apple_x, m_apple_y} !== {5'd3, 5'd14}) begin
      bad++; $display("FAIL eat_hold: got (%0d,%0d) want (3,14)", m_apple_x, m_apple_y);
    end
    m_head_vld = 0;
    for (int i = 0; i < 300 && m_busy; i++) tick();
    total++; if ({m_busy, m_apple_vld, m_eat_count} !== {2'b01, EXP_EAT1}) begin
      bad++; $display("FAIL eat_replace: got busy,vld=%b cnt=%0d want 01 cnt=%0d",
                      {m_busy, m_apple_vld}, m_eat_count, EXP_EAT1);
    end
  endtask

  task automatic test_spawn_ignored();
    int falls;
    logic prev, seen;
    m_seg_x[0] = 0;  m_seg_y[0] = 0;  m_seg_x[1] = 19; m_seg_y[1] = 19;
    m_seg_x[2] = 5;  m_seg_y[2] = 5;  m_seg_x[3] = 6;  m_seg_y[3] = 6;
    m_body_len = 7'd4;
    m_spawn_req = 1; tick(); m_spawn_req = 0;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (m_body_rd) seen = 1; else tick();
    end
    total++; if (seen !== 1'b1) begin
      bad++; $display("FAIL ign_scan_seen: got %b want 1", seen);
    end
    m_spawn_req = 1; tick(); m_spawn_req = 0;
    falls = 0; prev = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (prev && !m_busy) falls++;
      prev = m_busy;
      tick();
    end
    total++; if (falls !== 1 || m_busy !== 1'b0) begin
      bad++; $display("FAIL ign_one_place: got placements=%0d busy=%b want 1 0", falls, m_busy);
    end
  endtask

  task automatic test_reset_mid_scan();
    int events;
    logic seen;
    for (int i = 0; i < 10; i++) begin m_seg_x[i] = 5'(i); m_seg_y[i] = 5'd19; end
    m_body_len = 7'd10;
    m_spawn_req = 1; tick(); m_spawn_req = 0;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (m_body_rd) seen = 1; else tick();
    end
    total++; if (seen !== 1'b1) begin
      bad++; $display("FAIL rst_scan_seen: got %b want 1", seen);
    end
    m_rst_n = 0;
    #1;
    total++; if ({m_apple_vld, m_body_rd, m_busy} !== 3'b000) begin
      bad++; $display("FAIL rst_async: got vld,rd,busy=%b want 000", {m_apple_vld, m_body_rd, m_busy});
    end
    total++; if (u_main.lfsr !== 16'hACE1) begin
      bad++; $display("FAIL rst_lfsr: got %h want ace1", u_main.lfsr);
    end
    tick(); tick();
    m_rst_n = 1;
    events = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_busy || m_apple_vld) events++;
    end
    total++; if (events !== 0) begin
      bad++; $display("FAIL rst_no_place: got %0d active cycles want 0", events);
    end
  endtask

  // Returns at the negedge after the trigger edge; u_frc is then in GEN with
  // candidate (2,1).
  task automatic f_launch();
    f_rst_n = 0; tick(); f_rst_n = 1;
    tick(); tick();
    f_spawn_req = 1; tick(); f_spawn_req = 0;
  endtask

  task automatic test_gen_accept();
    f_body_len = 0; f_head_vld = 0;
    f_launch();
    total++; if ({f_busy, f_apple_vld} !== 2'b10) begin
      bad++; $display("FAIL acc_gen: got busy,vld=%b want 10", {f_busy, f_apple_vld});
    end
    tick();
    total++; if ({f_busy, f_apple_vld, f_apple_x, f_apple_y} !== {2'b01, 5'd2, 5'd1}) begin
      bad++; $display("FAIL acc_place: got busy,vld=%b (%0d,%0d) want 01 (2,1)",
                      {f_busy, f_apple_vld}, f_apple_x, f_apple_y);
    end
  endtask

  task automatic test_head_reject();
    f_body_len = 0; f_head_x = 2; f_head_y = 1; f_head_vld = 1;
    f_launch();
    tick();
    total++; if ({f_busy, f_apple_vld} !== 2'b10) begin
      bad++; $display("FAIL head_rej: got busy,vld=%b want 10", {f_busy, f_apple_vld});
    end
    for (int i = 0; i < 300 && f_busy; i++) tick();
    total++; if (f_apple_vld !== 1'b1 || {f_apple_x, f_apple_y} === {5'd2, 5'd1}) begin
      bad++; $display("FAIL head_final: got vld=%b (%0d,%0d) want 1 and not (2,1)",
                      f_apple_vld, f_apple_x, f_apple_y);
    end
    f_head_vld = 0;
  endtask

  task automatic test_scan_place();
    f_seg_x[0] = 10; f_seg_y[0] = 10; f_seg_x[1] = 11; f_seg_y[1] = 10;
    f_seg_x[2] = 12; f_seg_y[2] = 10;
    f_body_len = 3;
    f_launch();
    for (int a = 0; a < 3; a++) begin
      tick();
      total++; if ({f_body_rd, f_body_addr} !== {1'b1, 6'(a)}) begin
        bad++; $display("FAIL scan_addr%0d: got rd=%b addr=%0d want 1 %0d", a, f_body_rd, f_body_addr, a);
      end
    end
    tick();
    total++; if ({f_busy, f_body_rd, f_apple_vld} !== 3'b100) begin
      bad++; $display("FAIL scan_last_cmp: got busy,rd,vld=%b want 100", {f_busy, f_body_rd, f_apple_vld});
    end
    tick();
    total++; if ({f_busy, f_apple_vld, f_apple_x, f_apple_y} !== {2'b01, 5'd2, 5'd1}) begin
      bad++; $display("FAIL scan_place: got busy,vld=%b (%0d,%0d) want 01 (2,1)",
                      {f_busy, f_apple_vld}, f_apple_x, f_apple_y);
    end
  endtask

  task automatic test_scan_abort();
    logic hit;
    f_seg_x[0] = 1; f_seg_y[0] = 1; f_seg_x[1] = 2; f_seg_y[1] = 1;
    f_seg_x[2] = 3; f_seg_y[2] = 1;
    f_body_len = 3;
    f_launch();
    tick(); tick(); tick(); tick(); tick();
    total++; if ({f_busy, f_apple_vld} !== 2'b10) begin
      bad++; $display("FAIL abort_noplace: got busy,vld=%b want 10", {f_busy, f_apple_vld});
    end
    for (int i = 0; i < 400 && f_busy; i++) tick();
    hit = 0;
    for (int i = 0; i < 3; i++)
      if (f_apple_x == f_seg_x[i] && f_apple_y == f_seg_y[i]) hit = 1;
    total++; if (f_apple_vld !== 1'b1 || hit || f_apple_x >= 20 || f_apple_y >= 20) begin
      bad++; $display("FAIL abort_final: got vld=%b (%0d,%0d) want 1, in grid, off body",
                      f_apple_vld, f_apple_x, f_apple_y);
    end
  endtask

  task automatic test_small_grid();
    int bad_coord, timeouts;
    bad_coord = 0; timeouts = 0;
    s_rst_n = 1; tick();
    for (int n = 0; n < 1000; n++) begin
      s_spawn_req = 1; tick(); s_spawn_req = 0;
      for (int i = 0; i < 100 && s_busy; i++) tick();
      if (s_busy) timeouts++;
      if (s_apple_x == 2'd3 || s_apple_y == 2'd3 || !s_apple_vld) bad_coord++;
    end
    total++; if (timeouts !== 0) begin
      bad++; $display("FAIL small_timeout: got %0d want 0", timeouts);
    end
    total++; if (bad_coord !== 0) begin
      bad++; $display("FAIL small_range: got %0d bad placements want 0", bad_coord);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_spawn_empty();
    test_eat();
    test_spawn_ignored();
    test_reset_mid_scan();
    test_gen_accept();
    test_head_reject();
    test_scan_place();
    test_scan_abort();
    test_small_grid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
